// File: rtl/mfp_adc_max10_sequencer.sv
// Channel-scan sequencer for the MAX10 ADC IP: one Avalon-ST command per enabled mask bit, captures replies per channel.
// Optional interrupt output is enabled by defining MFP_ADC_MAX10_SEQ_IRQ_EN.
module mfp_adc_max10_sequencer #(
  parameter int N_CH         = 8,
  parameter int CH_OFFSET    = 1,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [N_CH-1:0]         cfg_mask,
  input  logic                    cfg_continuous,
  input  logic                    cfg_start,
  input  logic                    cfg_abort,
  input  logic [$clog2(N_CH)-1:0] rd_ch,
  output logic [11:0]             rd_data,
  output logic [N_CH-1:0]         sample_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
`ifdef MFP_ADC_MAX10_SEQ_IRQ_EN
  output logic                    irq,
  input  logic                    irq_clr,
`endif
  output logic [2:0]              dbg_state,
  output logic                    ADC_C_Valid,
  output logic [4:0]              ADC_C_Channel,
  output logic                    ADC_C_SOP,
  output logic                    ADC_C_EOP,
  input  logic                    ADC_C_Ready,
  input  logic                    ADC_R_Valid,
  input  logic [4:0]              ADC_R_Channel,
  input  logic [11:0]             ADC_R_Data,
  input  logic                    ADC_R_SOP,
  input  logic                    ADC_R_EOP
);

  localparam int IW = $clog2(N_CH);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_CMD    = 3'd2,
    S_RESP   = 3'd3,
    S_NEXT   = 3'd4
  } state_t;

  state_t          r_state;
  logic [N_CH-1:0] r_mask;
  logic [IW-1:0]   r_idx;
  logic            r_first;
  logic            r_abort;
  logic [TW-1:0]   r_tmo;
  logic [11:0]     r_sample [N_CH];
  logic [N_CH-1:0] r_sv;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_c_valid;
  logic [4:0]      r_c_ch;
  logic            r_c_sop;
  logic            r_c_eop;

  logic [IW-1:0]   w_sel;
  logic            w_sel_last;
  logic            w_more;
  logic            w_r_match;
  logic            w_unused;

  function automatic logic [IW-1:0] lowest_from(input logic [N_CH-1:0] m, input logic [IW-1:0] from);
    lowest_from = from;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i] && i >= int'(from)) lowest_from = IW'(i);
    end
  endfunction

  function automatic logic any_above(input logic [N_CH-1:0] m, input logic [IW-1:0] pos);
    any_above = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (m[i] && i > int'(pos)) any_above = 1'b1;
    end
  endfunction

  always_comb begin
    w_sel      = lowest_from(r_mask, r_idx);
    w_sel_last = !any_above(r_mask, w_sel);
    w_more     = any_above(r_mask, r_idx);
    w_r_match  = (ADC_R_Channel == (5'(r_idx) + 5'(CH_OFFSET)));
  end

  // Reply framing bits are not needed: every command yields exactly one reply.
  assign w_unused = ^{ADC_R_SOP, ADC_R_EOP};

  // Command handshake: Valid/Channel/SOP/EOP are held constant until a clock
  // edge sees ADC_C_Valid && ADC_C_Ready; that edge transfers exactly one command.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_idx     <= '0;
      r_first   <= 1'b0;
      r_abort   <= 1'b0;
      r_tmo     <= '0;
      r_sv      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_c_valid <= 1'b0;
      r_c_ch    <= '0;
      r_c_sop   <= 1'b0;
      r_c_eop   <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_sample[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (cfg_abort && r_state != S_IDLE) r_abort <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_mask  <= cfg_mask;
            r_sv    <= '0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_first <= 1'b1;
            r_abort <= 1'b0;
            if (cfg_mask == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_SELECT;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SELECT: begin
          r_idx     <= w_sel;
          r_c_valid <= 1'b1;
          r_c_ch    <= 5'(w_sel) + 5'(CH_OFFSET);
          r_c_sop   <= r_first;
          r_c_eop   <= w_sel_last;
          r_state   <= S_CMD;
        end
        S_CMD: begin
          if (ADC_C_Ready) begin
            r_c_valid <= 1'b0;
            r_c_sop   <= 1'b0;
            r_c_eop   <= 1'b0;
            r_first   <= 1'b0;
            r_tmo     <= '0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (ADC_R_Valid && w_r_match) begin
            r_sample[r_idx] <= ADC_R_Data;
            r_sv[r_idx]     <= 1'b1;
            r_state         <= S_NEXT;
          end else begin
            if (ADC_R_Valid) r_err <= 1'b1;
            if (r_tmo == TMO_LAST) begin
              r_err   <= 1'b1;
              r_state <= S_NEXT;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end
        S_NEXT: begin
          if (r_abort || cfg_abort) begin
            r_abort <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_more) begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_SELECT;
          end else begin
            r_done <= 1'b1;
            if (cfg_continuous) begin
              r_mask  <= cfg_mask;
              r_idx   <= '0;
              r_first <= 1'b1;
              if (cfg_mask == '0) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_SELECT;
              end
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MFP_ADC_MAX10_SEQ_IRQ_EN
  logic r_err_d;
  logic r_irq;

  // A set event wins over a simultaneous clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_err_d <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_err_d <= r_err;
      r_irq   <= (r_irq & ~irq_clr) | r_done | (r_err & ~r_err_d);
    end
  end

  assign irq = r_irq;
`endif

  assign rd_data       = r_sample[rd_ch];
  assign sample_valid  = r_sv;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign dbg_state     = r_state;
  assign ADC_C_Valid   = r_c_valid;
  assign ADC_C_Channel = r_c_ch;
  assign ADC_C_SOP     = r_c_sop;
  assign ADC_C_EOP     = r_c_eop;

endmodule

// File: tb/tb_mfp_adc_max10_sequencer.sv
// Directed bench for mfp_adc_max10_sequencer: ADC responder, command scoreboard, status checks.
module tb_mfp_adc_max10_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [7:0]  cfg_mask;
  logic        cfg_continuous;
  logic        cfg_start;
  logic        cfg_abort;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic [7:0]  sample_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;
  logic        ADC_C_Valid;
  logic [4:0]  ADC_C_Channel;
  logic        ADC_C_SOP;
  logic        ADC_C_EOP;
  logic        ADC_C_Ready;
  logic        ADC_R_Valid;
  logic [4:0]  ADC_R_Channel;
  logic [11:0] ADC_R_Data;
  logic        ADC_R_SOP;
  logic        ADC_R_EOP;
`ifdef MFP_ADC_MAX10_SEQ_IRQ_EN
  logic        irq;
  logic        irq_clr;
`endif

  int checks   = 0;
  int failures = 0;
  int cmd_cnt  = 0;
  int done_cnt = 0;
  int resp_lat = 10;
  bit mismatch_once = 1'b0;
  logic [11:0] data_tab [32];
  logic [6:0]  exp_q [$];

  mfp_adc_max10_sequencer dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cfg_mask(cfg_mask), .cfg_continuous(cfg_continuous),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .rd_ch(rd_ch), .rd_data(rd_data), .sample_valid(sample_valid),
    .busy(busy), .done(done), .err(err),
`ifdef MFP_ADC_MAX10_SEQ_IRQ_EN
    .irq(irq), .irq_clr(irq_clr),
`endif
    .dbg_state(dbg_state),
    .ADC_C_Valid(ADC_C_Valid), .ADC_C_Channel(ADC_C_Channel),
    .ADC_C_SOP(ADC_C_SOP), .ADC_C_EOP(ADC_C_EOP), .ADC_C_Ready(ADC_C_Ready),
    .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data),
    .ADC_R_SOP(ADC_R_SOP), .ADC_R_EOP(ADC_R_EOP)
  );

  // Clock / watchdog
  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push_cmd(input logic [4:0] ch, input logic sop, input logic eop);
    exp_q.push_back({ch, sop, eop});
  endtask

  task automatic pulse_start(input logic [7:0] mask);
    cfg_mask  = mask;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge HCLK);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge HCLK);
      n++;
    end
    check("busy_drop_within_budget", busy, 1'b0);
    @(negedge HCLK);
  endtask

  always @(negedge HCLK) if (done === 1'b1) done_cnt++;

  // ADC model: scoreboards each transferred command, then answers after resp_lat cycles.
  initial begin : adc_model
    logic [6:0] got;
    logic [6:0] exp;
    logic [4:0] ch;
    ADC_R_Valid   = 1'b0;
    ADC_R_Channel = '0;
    ADC_R_Data    = '0;
    ADC_R_SOP     = 1'b0;
    ADC_R_EOP     = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESETn === 1'b1 && ADC_C_Valid === 1'b1 && ADC_C_Ready === 1'b1) begin
        cmd_cnt++;
        got = {ADC_C_Channel, ADC_C_SOP, ADC_C_EOP};
        ch  = ADC_C_Channel;
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL cmd_unexpected observed=0x%0h expected=none", got);
        end
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check("cmd_ch_sop_eop", got, exp);
        end
        repeat (resp_lat) @(negedge HCLK);
        ADC_R_Valid   = 1'b1;
        ADC_R_Channel = mismatch_once ? 5'd5 : ch;
        ADC_R_Data    = data_tab[ch];
        ADC_R_SOP     = 1'b1;
        ADC_R_EOP     = 1'b1;
        @(negedge HCLK);
        ADC_R_Valid   = 1'b0;
        ADC_R_SOP     = 1'b0;
        ADC_R_EOP     = 1'b0;
        mismatch_once = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int base_cmd;
    int base_done;
    int n;
    for (int i = 0; i < 32; i++) data_tab[i] = 12'($urandom_range(0, 4095));
    data_tab[1] = 12'h123;
    data_tab[3] = 12'h456;

    HRESETn = 1'b0;
    cfg_mask = '0; cfg_continuous = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    rd_ch = '0; ADC_C_Ready = 1'b1;
`ifdef MFP_ADC_MAX10_SEQ_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (3) @(negedge HCLK);
    check("rst_c_valid", ADC_C_Valid, 1'b0);
    check("rst_c_channel", ADC_C_Channel, 5'd0);
    check("rst_c_sop_eop", {ADC_C_SOP, ADC_C_EOP}, 2'b00);
    check("rst_busy_done_err", {busy, done, err}, 3'b000);
    check("rst_sample_valid", sample_valid, 8'h00);
    check("rst_rd_data", rd_data, 12'h000);
    HRESETn = 1'b1;
    tick();

    // Single pass, mask 0x05, with a start/mask change while busy
    resp_lat = 10;
    push_cmd(5'd1, 1'b1, 1'b0);
    push_cmd(5'd3, 1'b0, 1'b1);
    base_cmd = cmd_cnt; base_done = done_cnt;
    pulse_start(8'h05);
    @(negedge HCLK);
    check("select_busy", busy, 1'b1);
    check("select_no_valid", ADC_C_Valid, 1'b0);
    @(negedge HCLK);
    check("cmd_valid_n2", ADC_C_Valid, 1'b1);
    check("cmd_first_ch", ADC_C_Channel, 5'd1);
    pulse_start(8'hFF);
    wait_idle(500);
    check("pass1_cmds", cmd_cnt - base_cmd, 2);
    check("pass1_done", done_cnt - base_done, 1);
    check("pass1_sv", sample_valid, 8'h05);
    check("pass1_err", err, 1'b0);
    rd_ch = 3'd0; #1;
    check("pass1_rd0", rd_data, 12'h123);
    rd_ch = 3'd2; #1;
    check("pass1_rd2", rd_data, 12'h456);
    check("pass1_queue_empty", exp_q.size(), 0);

    // Mismatch then silence on ch1 -> timeout
    tick();
    mismatch_once = 1'b1;
    push_cmd(5'd1, 1'b1, 1'b1);
    base_done = done_cnt;
    pulse_start(8'h01);
    repeat (100) @(negedge HCLK);
    check("tmo_still_busy", busy, 1'b1);
    check("tmo_mismatch_err", err, 1'b1);
    wait_idle(600);
    check("tmo_err", err, 1'b1);
    check("tmo_done", done_cnt - base_done, 1);
    check("tmo_sv", sample_valid, 8'h00);
    rd_ch = 3'd0; #1;
    check("tmo_sample_kept", rd_data, 12'h123);

    // Ready stall on ch2
    tick();
    ADC_C_Ready = 1'b0;
    push_cmd(5'd2, 1'b1, 1'b1);
    base_cmd = cmd_cnt;
    pulse_start(8'h02);
    @(negedge HCLK);
    check("start_clears_err", err, 1'b0);
    n = 0;
    while (ADC_C_Valid !== 1'b1 && n < 20) begin @(negedge HCLK); n++; end
    for (int k = 0; k < 7; k++) begin
      check("stall_valid", ADC_C_Valid, 1'b1);
      check("stall_channel", ADC_C_Channel, 5'd2);
      check("stall_sop_eop", {ADC_C_SOP, ADC_C_EOP}, 2'b11);
      @(negedge HCLK);
    end
    tick();
    ADC_C_Ready = 1'b1;
    wait_idle(500);
    check("stall_one_cmd", cmd_cnt - base_cmd, 1);
    check("stall_sv", sample_valid, 8'h02);
    rd_ch = 3'd1; #1;
    check("stall_rd1", rd_data, data_tab[2]);

    // Continuous 0xFF: two full passes, abort during RESP on ch4 of the third
    tick();
    resp_lat = 4;
    cfg_continuous = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) push_cmd(5'(i + 1), i == 0, i == 7);
    for (int i = 0; i < 4; i++) push_cmd(5'(i + 1), i == 0, 1'b0);
    base_cmd = cmd_cnt; base_done = done_cnt;
    pulse_start(8'hFF);
    n = 0;
    while (cmd_cnt - base_cmd < 20 && n < 2000) begin @(negedge HCLK); n++; end
    check("cont_reached_ch4", cmd_cnt - base_cmd, 20);
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    wait_idle(500);
    check("abort_done_count", done_cnt - base_done, 2);
    check("abort_cmds", cmd_cnt - base_cmd, 20);
    check("abort_queue_empty", exp_q.size(), 0);
    check("abort_sv", sample_valid, 8'hFF);
    repeat (20) @(negedge HCLK);
    check("abort_stays_idle", {busy, ADC_C_Valid}, 2'b00);
    for (int i = 0; i < 8; i++) begin
      rd_ch = 3'(i); #1;
      check("cont_rd", rd_data, data_tab[i + 1]);
    end
    cfg_continuous = 1'b0;

    // Empty mask
    tick();
    base_cmd = cmd_cnt;
    pulse_start(8'h00);
    @(negedge HCLK);
    check("mask0_done", done, 1'b1);
    check("mask0_busy", busy, 1'b0);
    check("mask0_sv_cleared", sample_valid, 8'h00);
    @(negedge HCLK);
    check("mask0_done_one_cycle", done, 1'b0);
    check("mask0_no_cmd", cmd_cnt - base_cmd, 0);

    // Reset mid-CMD
    tick();
    ADC_C_Ready = 1'b0;
    pulse_start(8'h01);
    repeat (2) @(negedge HCLK);
    check("pre_rst_valid", ADC_C_Valid, 1'b1);
    HRESETn = 1'b0;
    #1;
    check("rst_mid_valid", ADC_C_Valid, 1'b0);
    check("rst_mid_channel", ADC_C_Channel, 5'd0);
    check("rst_mid_status", {busy, done, err, ADC_C_SOP, ADC_C_EOP}, 5'b00000);
    check("rst_mid_sv", sample_valid, 8'h00);
    rd_ch = 3'd0; #1;
    check("rst_mid_sample", rd_data, 12'h000);
    @(negedge HCLK);
    HRESETn = 1'b1;
    ADC_C_Ready = 1'b1;
    tick();

`ifdef MFP_ADC_MAX10_SEQ_IRQ_EN
    check("irq_reset", irq, 1'b0);
    pulse_start(8'h00);
    repeat (2) @(negedge HCLK);
    check("irq_on_done", irq, 1'b1);
    tick();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    @(negedge HCLK);
    check("irq_cleared", irq, 1'b0);
    tick();
    pulse_start(8'h00);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    @(negedge HCLK);
    check("irq_set_beats_clr", irq, 1'b1);
`endif

    repeat (5) @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
